// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the control unit and the sequential RISC-V M-extension unit.
// The control unit holds the master side; muldiv_seq is the slave.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_val, rs2_val,
    input  stall, done, result
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val,
    output stall, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide on magnitudes,
// one iteration per clock, with divide-by-zero and signed-overflow short-circuited straight to DONE.
//
//   state  | meaning
//   IDLE   | waiting for start; latches op and operand magnitudes on accept
//   CALC   | one shift-add / shift-subtract step per cycle, XLEN steps
//   DONE   | one-cycle done pulse, result register just updated
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2:0]      OP_MUL   = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode at the IDLE boundary
  logic            is_div;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div0, ovf;
  logic [XLEN-1:0] special_res;

  assign is_div   = bus.funct3[2];
  assign a_signed = ~(bus.funct3[1] & bus.funct3[0]) & ~(bus.funct3[2] & bus.funct3[0]);
  assign b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign a_neg    = a_signed & bus.rs1_val[XLEN-1];
  assign b_neg    = b_signed & bus.rs2_val[XLEN-1];
  assign a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
  assign b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;
  assign div0     = is_div && (bus.rs2_val == '0);
  assign ovf      = is_div && !bus.funct3[0] && (bus.rs1_val == MIN_INT) && (&bus.rs2_val);

  always_comb begin
    special_res = '0;
    if (div0)
      special_res = bus.funct3[1] ? bus.rs1_val : '1;
    else
      special_res = bus.funct3[1] ? '0 : MIN_INT;
  end

  // Multiply step: {hi,lo} holds partial product over the remaining multiplier bits
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi, mul_lo;
  logic [2*XLEN-1:0] prod, prod_s;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi  = mul_sum[XLEN:1];
  assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
  assign prod    = {mul_hi, mul_lo};
  assign prod_s  = neg_q ? -prod : prod;

  // Divide step: hi is the partial remainder, lo shifts dividend bits out and quotient bits in
  logic [XLEN:0]   div_sh, div_sub;
  logic            div_ge;
  logic [XLEN-1:0] div_hi, div_lo;
  logic            unused_bits;

  assign div_sh      = {hi_q, lo_q[XLEN-1]};
  assign div_sub     = div_sh - {1'b0, opnd_q};
  assign div_ge      = div_sh >= {1'b0, opnd_q};
  assign div_hi      = div_ge ? div_sub[XLEN-1:0] : div_sh[XLEN-1:0];
  assign div_lo      = {lo_q[XLEN-2:0], div_ge};
  assign unused_bits = ^{div_sub[XLEN], div_sh[XLEN]};

  logic [XLEN-1:0] fin_res;

  always_comb begin
    fin_res = '0;
    if (op_q[2]) begin
      if (op_q[1])
        fin_res = rneg_q ? -div_hi : div_hi;
      else
        fin_res = neg_q ? -div_lo : div_lo;
    end else begin
      fin_res = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = bus.funct3;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          hi_d   = '0;
          lo_d   = is_div ? a_mag : b_mag;
          opnd_d = is_div ? b_mag : a_mag;
          if (div0 || ovf) begin
            cnt_d    = '0;
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = special_res;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_ONE;
        hi_d  = op_q[2] ? div_hi : mul_hi;
        lo_d  = op_q[2] ? div_lo : mul_lo;
        if (cnt_q == CNT_ONE) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = fin_res;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Stall covers the accepting IDLE cycle so the pipeline freezes before the op is latched
  assign bus.stall  = ((state_q == S_IDLE) && bus.start && !rst) || (state_q == S_CALC);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request from the control unit for a decoded M-extension op (opcode 0110011, funct7 0000001).
REQ-005 The block SHALL have port funct3, input, 3, op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have port rs1_val, input, XLEN, operand A (multiplicand or dividend).
REQ-007 The block SHALL have port rs2_val, input, XLEN, operand B (multiplier or divisor).
REQ-008 The block SHALL have port stall, output, 1, freezes the PC and register-file write while the op is in flight.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-010 The block SHALL have port result, output, XLEN, value for rd.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch funct3 and both operands, load the counter with XLEN, and go to CALC on the next edge; CALC SHALL never be entered without a valid latch.
REQ-013 The stall output SHALL be combinational: 1 when (state==IDLE and start==1 and rst==0) or state==CALC; 0 otherwise, including in DONE.
REQ-014 CALC SHALL perform one iteration per cycle for exactly XLEN cycles, then move to DONE.
REQ-015 Multiply SHALL use radix-2 shift-add on operand magnitudes into a 2*XLEN product.
REQ-016 Multiply signedness: MUL and MULH SHALL treat both operands as signed, MULHSU SHALL treat A as signed and B as unsigned, and MULHU SHALL treat both as unsigned.
REQ-017 After a multiply, the product SHALL be negated when the operand signs differ; MUL SHALL return the low XLEN bits and all other multiply ops the high XLEN bits.
REQ-018 Divide SHALL use restoring shift-subtract on magnitudes; DIV and REM are signed, DIVU and REMU are unsigned.
REQ-019 For signed divide, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-020 Divide by zero (rs2_val==0) SHALL skip CALC and go IDLE->DONE in one cycle: DIV/DIVU SHALL return all-ones, and REM/REMU SHALL return rs1_val.
REQ-021 Signed overflow (DIV/REM with A=0x80000000 and B=0xFFFFFFFF) SHALL skip CALC: DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-022 Normal-op latency: start sampled at edge N SHALL give done=1 and a valid result in cycle N+XLEN+1, with the FSM back in IDLE at N+XLEN+2.
REQ-023 Special-case latency (REQ-020 and REQ-021) SHALL be done=1 at cycle N+1.
REQ-024 In DONE, the block SHALL assert done for exactly one cycle and return to IDLE unconditionally; start seen in DONE SHALL be ignored.
REQ-025 A start seen in CALC SHALL be ignored, and changes to the operands or funct3 after the latch SHALL have no effect.
REQ-026 The result output SHALL update only on entry to DONE and hold its value until the next DONE.
REQ-027 The counter SHALL be ceil(log2(XLEN))+1 bits wide and SHALL never wrap: CALC exits when the counter reaches 0.
REQ-028 A start in IDLE on the cycle after DONE SHALL be accepted, giving back-to-back ops with no bubble beyond the IDLE cycle.

Reset
REQ-029 While rst=1, at every edge the block SHALL force the state to IDLE, the counter to 0, done to 0, result to 0 and all latched operands to 0.
REQ-030 While rst=1, stall SHALL be 0 and start SHALL be ignored.
REQ-031 Reset asserted in CALC or DONE SHALL abort the op with no done pulse; the first edge after rst drops SHALL accept start.

Verification
REQ-032 MUL with A=7 and B=-3 (0xFFFFFFFD) -> stall high for 33 cycles, done at N+33, result 0xFFFFFFEB.
REQ-033 MULHU with A=0xFFFFFFFF and B=0xFFFFFFFF -> result 0xFFFFFFFE; MULH with the same operands -> result 0x00000000.
REQ-034 DIV with A=-20 and B=6 -> result 0xFFFFFFFD (-3); REM with the same operands -> result 0xFFFFFFFE (-2); DIVU with A=20 and B=6 -> result 3.
REQ-035 DIVU with A=5 and B=0 -> done at N+1, result 0xFFFFFFFF; REM with A=5 and B=0 -> result 5; DIV with A=0x80000000 and B=-1 -> result 0x80000000 at N+1.
REQ-036 Hold start high for 40 cycles with different operands -> exactly one op accepted per IDLE visit, each done pulse one cycle wide, and result matching the operands latched at acceptance.
REQ-037 Assert rst at cycle 10 of CALC -> no done pulse, stall 0 on the next cycle, result 0; a new MUL with A=2 and B=3 then returns 6.
